// File: rtl/video_timing_pkg.sv
// Shared raster timing constants, FSM state encoding and line/frame phase encoding.
package video_timing_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        PH_SYNC = 2'd0,
        PH_BP   = 2'd1,
        PH_ACT  = 2'd2,
        PH_FP   = 2'd3
    } phase_t;

    // CEA 1280x720@60, 74.25 MHz pixel clock
    localparam int T720_H_SYNC  = 40;
    localparam int T720_H_BP    = 220;
    localparam int T720_H_ACT   = 1280;
    localparam int T720_H_FP    = 110;
    localparam int T720_V_SYNC  = 5;
    localparam int T720_V_BP    = 20;
    localparam int T720_V_ACT   = 720;
    localparam int T720_V_FP    = 5;

    // CEA 1920x1080@60, 148.5 MHz pixel clock
    localparam int T1080_H_SYNC = 44;
    localparam int T1080_H_BP   = 148;
    localparam int T1080_H_ACT  = 1920;
    localparam int T1080_H_FP   = 88;
    localparam int T1080_V_SYNC = 5;
    localparam int T1080_V_BP   = 36;
    localparam int T1080_V_ACT  = 1080;
    localparam int T1080_V_FP   = 4;

    localparam logic HS_POL_DEF = 1'b1;
    localparam logic VS_POL_DEF = 1'b1;

endpackage

// File: rtl/timing_axis_cnt.sv
// One raster axis: wrap counter over SYNC+BP+ACT+FP with phase decode and active-area offset.
module timing_axis_cnt
    import video_timing_pkg::*;
#(
    parameter int BITS = 12,
    parameter int SYNC = 40,
    parameter int BP   = 220,
    parameter int ACT  = 1280,
    parameter int FP   = 110
) (
    input  logic            pix_clk,
    input  logic            rstn,
    input  logic            i_clr,
    input  logic            i_inc,
    output logic [BITS-1:0] o_cnt,
    output logic            o_last,
    output phase_t          o_phase,
    output logic [BITS-1:0] o_act_pos
);

    localparam int              TOTAL  = SYNC + BP + ACT + FP;
    localparam logic [BITS-1:0] L_LAST = BITS'(TOTAL - 1);
    localparam logic [BITS-1:0] L_BP0  = BITS'(SYNC);
    localparam logic [BITS-1:0] L_ACT0 = BITS'(SYNC + BP);
    localparam logic [BITS-1:0] L_FP0  = BITS'(SYNC + BP + ACT);

    logic [BITS-1:0] r_cnt;

    always_ff @(posedge pix_clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= (r_cnt == L_LAST) ? '0 : r_cnt + BITS'(1);
        end
    end

    always_comb begin
        o_phase = PH_FP;
        if (r_cnt < L_BP0) begin
            o_phase = PH_SYNC;
        end else if (r_cnt < L_ACT0) begin
            o_phase = PH_BP;
        end else if (r_cnt < L_FP0) begin
            o_phase = PH_ACT;
        end
    end

    assign o_cnt     = r_cnt;
    assign o_last    = (r_cnt == L_LAST);
    // Only meaningful while o_phase is PH_ACT; the top gates it.
    assign o_act_pos = r_cnt - L_ACT0;

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: registered vs/hs/de, active coordinates and frame_start,
// decoded one cycle after the h/v counters.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int   X_BITS = 12,
    parameter int   Y_BITS = 12,
    parameter int   H_SYNC = T720_H_SYNC,
    parameter int   H_BP   = T720_H_BP,
    parameter int   H_ACT  = T720_H_ACT,
    parameter int   H_FP   = T720_H_FP,
    parameter int   V_SYNC = T720_V_SYNC,
    parameter int   V_BP   = T720_V_BP,
    parameter int   V_ACT  = T720_V_ACT,
    parameter int   V_FP   = T720_V_FP,
    parameter logic HS_POL = HS_POL_DEF,
    parameter logic VS_POL = VS_POL_DEF
) (
    input  logic              pix_clk,
    input  logic              rstn,
    input  logic              en,
    output logic              vs_out,
    output logic              hs_out,
    output logic              de_out,
    output logic [X_BITS-1:0] act_x,
    output logic [Y_BITS-1:0] act_y,
    output logic              frame_start
);

    localparam longint H_TOTAL = longint'(H_SYNC) + H_BP + H_ACT + H_FP;
    localparam longint V_TOTAL = longint'(V_SYNC) + V_BP + V_ACT + V_FP;

    if (X_BITS < 1 || Y_BITS < 1 || X_BITS > 62 || Y_BITS > 62 ||
        H_SYNC < 1 || H_BP < 1 || H_ACT < 1 || H_FP < 1 ||
        V_SYNC < 1 || V_BP < 1 || V_ACT < 1 || V_FP < 1 ||
        H_TOTAL >= (longint'(1) << X_BITS) || V_TOTAL >= (longint'(1) << Y_BITS)) begin : g_param_check
        $fatal(1, "video_timing_gen: timing does not fit counter widths");
    end

    state_t            r_state;
    logic              r_vs;
    logic              r_hs;
    logic              r_de;
    logic [X_BITS-1:0] r_act_x;
    logic [Y_BITS-1:0] r_act_y;
    logic              r_fs;

    logic              w_run;
    logic              w_clr;
    logic              w_h_inc;
    logic              w_v_inc;
    logic              w_de;
    logic [X_BITS-1:0] w_h_cnt;
    logic [X_BITS-1:0] w_h_pos;
    logic              w_h_last;
    phase_t            w_h_phase;
    logic [Y_BITS-1:0] w_v_cnt;
    logic [Y_BITS-1:0] w_v_pos;
    logic              w_v_last_unused;
    phase_t            w_v_phase;

    assign w_run   = (r_state == ST_RUN);
    // Counters hold at zero while idle and on the en-rise edge, so a restart is always h=0,v=0.
    assign w_clr   = !w_run || !en;
    assign w_h_inc = w_run && en;
    assign w_v_inc = w_h_inc && w_h_last;
    assign w_de    = w_run && (w_h_phase == PH_ACT) && (w_v_phase == PH_ACT);

    timing_axis_cnt #(
        .BITS (X_BITS),
        .SYNC (H_SYNC),
        .BP   (H_BP),
        .ACT  (H_ACT),
        .FP   (H_FP)
    ) u_h_axis (
        .pix_clk   (pix_clk),
        .rstn      (rstn),
        .i_clr     (w_clr),
        .i_inc     (w_h_inc),
        .o_cnt     (w_h_cnt),
        .o_last    (w_h_last),
        .o_phase   (w_h_phase),
        .o_act_pos (w_h_pos)
    );

    timing_axis_cnt #(
        .BITS (Y_BITS),
        .SYNC (V_SYNC),
        .BP   (V_BP),
        .ACT  (V_ACT),
        .FP   (V_FP)
    ) u_v_axis (
        .pix_clk   (pix_clk),
        .rstn      (rstn),
        .i_clr     (w_clr),
        .i_inc     (w_v_inc),
        .o_cnt     (w_v_cnt),
        .o_last    (w_v_last_unused),
        .o_phase   (w_v_phase),
        .o_act_pos (w_v_pos)
    );

    always_ff @(posedge pix_clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
            r_vs    <= ~VS_POL;
            r_hs    <= ~HS_POL;
            r_de    <= 1'b0;
            r_act_x <= '0;
            r_act_y <= '0;
            r_fs    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: if (en)  r_state <= ST_RUN;
                default: if (!en) r_state <= ST_IDLE;
            endcase
            r_vs    <= (w_run && w_v_phase == PH_SYNC) ? VS_POL : ~VS_POL;
            r_hs    <= (w_run && w_h_phase == PH_SYNC) ? HS_POL : ~HS_POL;
            r_de    <= w_de;
            r_act_x <= w_de ? w_h_pos : '0;
            r_act_y <= (w_run && w_v_phase == PH_ACT) ? w_v_pos : '0;
            r_fs    <= w_run && (w_h_cnt == '0) && (w_v_cnt == '0);
        end
    end

    assign vs_out      = r_vs;
    assign hs_out      = r_hs;
    assign de_out      = r_de;
    assign act_x       = r_act_x;
    assign act_y       = r_act_y;
    assign frame_start = r_fs;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: 720p instance (line/frame spot table, async reset) and a tiny
// inverted-sync instance (wraps, enable drop/restart), both under a per-cycle scoreboard model.
module tb_video_timing_gen;

    typedef struct packed {
        logic        vs;
        logic        hs;
        logic        de;
        logic [11:0] x;
        logic [11:0] y;
        logic        fs;
    } vout_t;

    typedef struct packed {
        int   hs_w, hbp, hact, hfp, vs_w, vbp, vact, vfp;
        logic hpol, vpol;
    } cfg_t;

    typedef struct {
        int   t;
        logic vs, hs, de;
        int   x, y;
        logic fs;
    } vec_t;

    localparam cfg_t CFG_A = '{40, 220, 1280, 110, 5, 20, 720, 5, 1'b1, 1'b1};
    localparam cfg_t CFG_B = '{2, 3, 8, 3, 1, 2, 4, 1, 1'b0, 1'b0};
    localparam int   NV    = 17;

    logic pix_clk = 1'b0;
    always #5 pix_clk = ~pix_clk;

    logic        rstn_a = 1'b1, en_a = 1'b0;
    logic        rstn_b = 1'b1, en_b = 1'b0;
    logic        vs_a, hs_a, de_a, fs_a;
    logic [11:0] ax_a, ay_a;
    logic        vs_b, hs_b, de_b, fs_b;
    logic [4:0]  ax_b;
    logic [3:0]  ay_b;

    int n_checks = 0;
    int n_fail   = 0;
    int done_a   = 0;
    int done_b   = 0;

    vout_t qa[$];
    vout_t qb[$];
    vec_t  vecs[NV];

    video_timing_gen dut_a (
        .pix_clk(pix_clk), .rstn(rstn_a), .en(en_a),
        .vs_out(vs_a), .hs_out(hs_a), .de_out(de_a),
        .act_x(ax_a), .act_y(ay_a), .frame_start(fs_a)
    );

    video_timing_gen #(
        .X_BITS(5), .Y_BITS(4),
        .H_SYNC(2), .H_BP(3), .H_ACT(8), .H_FP(3),
        .V_SYNC(1), .V_BP(2), .V_ACT(4), .V_FP(1),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut_b (
        .pix_clk(pix_clk), .rstn(rstn_b), .en(en_b),
        .vs_out(vs_b), .hs_out(hs_b), .de_out(de_b),
        .act_x(ax_b), .act_y(ay_b), .frame_start(fs_b)
    );

    function automatic vout_t mk(input logic vs, input logic hs, input logic de,
                                 input int x, input int y, input logic fs);
        vout_t o;
        o.vs = vs; o.hs = hs; o.de = de;
        o.x  = 12'(x); o.y = 12'(y); o.fs = fs;
        return o;
    endfunction

    // Expected outputs for a registered decode of (run, h, v).
    function automatic vout_t decode(input cfg_t c, input bit run, input int h, input int v);
        vout_t o;
        int ha0, va0;
        o = mk(~c.vpol, ~c.hpol, 1'b0, 0, 0, 1'b0);
        ha0 = c.hs_w + c.hbp;
        va0 = c.vs_w + c.vbp;
        if (run) begin
            if (h < c.hs_w) o.hs = c.hpol;
            if (v < c.vs_w) o.vs = c.vpol;
            if (v >= va0 && v < va0 + c.vact) begin
                o.y = 12'(v - va0);
                if (h >= ha0 && h < ha0 + c.hact) begin
                    o.de = 1'b1;
                    o.x  = 12'(h - ha0);
                end
            end
            o.fs = (h == 0 && v == 0);
        end
        return o;
    endfunction

    function automatic vout_t got_a();
        return {vs_a, hs_a, de_a, ax_a, ay_a, fs_a};
    endfunction

    function automatic vout_t got_b();
        return {vs_b, hs_b, de_b, 7'd0, ax_b, 8'd0, ay_b, fs_b};
    endfunction

    function automatic void check(input string name, input vout_t got, input vout_t exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got vs=%b hs=%b de=%b x=%0d y=%0d fs=%b, expected vs=%b hs=%b de=%b x=%0d y=%0d fs=%b",
                     name, $time, got.vs, got.hs, got.de, got.x, got.y, got.fs,
                     exp.vs, exp.hs, exp.de, exp.x, exp.y, exp.fs);
        end
    endfunction

    // Reference raster state, advanced on each clock edge from the sampled inputs.
    bit ma_run = 0, mb_run = 0;
    int ma_h = 0, ma_v = 0, mb_h = 0, mb_v = 0;

    always @(posedge pix_clk) begin
        if (!rstn_a) begin
            ma_run = 0; ma_h = 0; ma_v = 0;
            qa.push_back(decode(CFG_A, 0, 0, 0));
        end else begin
            qa.push_back(decode(CFG_A, ma_run, ma_h, ma_v));
            if (!ma_run) begin
                if (en_a) ma_run = 1;
            end else if (!en_a) begin
                ma_run = 0; ma_h = 0; ma_v = 0;
            end else if (ma_h == 1649) begin
                ma_h = 0;
                ma_v = (ma_v == 749) ? 0 : ma_v + 1;
            end else begin
                ma_h++;
            end
        end
    end

    always @(posedge pix_clk) begin
        if (!rstn_b) begin
            mb_run = 0; mb_h = 0; mb_v = 0;
            qb.push_back(decode(CFG_B, 0, 0, 0));
        end else begin
            qb.push_back(decode(CFG_B, mb_run, mb_h, mb_v));
            if (!mb_run) begin
                if (en_b) mb_run = 1;
            end else if (!en_b) begin
                mb_run = 0; mb_h = 0; mb_v = 0;
            end else if (mb_h == 15) begin
                mb_h = 0;
                mb_v = (mb_v == 7) ? 0 : mb_v + 1;
            end else begin
                mb_h++;
            end
        end
    end

    always @(negedge pix_clk) begin
        vout_t exp;
        if (qa.size() > 0) begin
            exp = qa.pop_front();
            if (!rstn_a) exp = decode(CFG_A, 0, 0, 0);
            check("sb_720p", got_a(), exp);
        end
        if (qb.size() > 0) begin
            exp = qb.pop_front();
            if (!rstn_b) exp = decode(CFG_B, 0, 0, 0);
            check("sb_small", got_b(), exp);
        end
    end

    task automatic at_a(input int t);
        repeat (t + 1 - done_a) @(posedge pix_clk);
        done_a = t + 1;
        #1;
    endtask

    task automatic at_b(input int t);
        repeat (t + 1 - done_b) @(posedge pix_clk);
        done_b = t + 1;
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        //           t      vs    hs    de    x     y  fs
        vecs[0]  = '{0,     1'b1, 1'b1, 1'b0, 0,    0, 1'b1};
        vecs[1]  = '{1,     1'b1, 1'b1, 1'b0, 0,    0, 1'b0};
        vecs[2]  = '{39,    1'b1, 1'b1, 1'b0, 0,    0, 1'b0};
        vecs[3]  = '{40,    1'b1, 1'b0, 1'b0, 0,    0, 1'b0};
        vecs[4]  = '{1649,  1'b1, 1'b0, 1'b0, 0,    0, 1'b0};
        vecs[5]  = '{1650,  1'b1, 1'b1, 1'b0, 0,    0, 1'b0};
        vecs[6]  = '{8249,  1'b1, 1'b0, 1'b0, 0,    0, 1'b0};
        vecs[7]  = '{8250,  1'b0, 1'b1, 1'b0, 0,    0, 1'b0};
        vecs[8]  = '{39900, 1'b0, 1'b0, 1'b0, 0,    0, 1'b0};
        vecs[9]  = '{41250, 1'b0, 1'b1, 1'b0, 0,    0, 1'b0};
        vecs[10] = '{41509, 1'b0, 1'b0, 1'b0, 0,    0, 1'b0};
        vecs[11] = '{41510, 1'b0, 1'b0, 1'b1, 0,    0, 1'b0};
        vecs[12] = '{41511, 1'b0, 1'b0, 1'b1, 1,    0, 1'b0};
        vecs[13] = '{42789, 1'b0, 1'b0, 1'b1, 1279, 0, 1'b0};
        vecs[14] = '{42790, 1'b0, 1'b0, 1'b0, 0,    0, 1'b0};
        vecs[15] = '{42900, 1'b0, 1'b1, 1'b0, 0,    1, 1'b0};
        vecs[16] = '{43160, 1'b0, 1'b0, 1'b1, 0,    1, 1'b0};

        #1;
        rstn_a = 1'b0;
        rstn_b = 1'b0;
        en_a   = 1'b1;
        #1 check("rst_async_a", got_a(), mk(0, 0, 0, 0, 0, 0));
        check("rst_async_b", got_b(), mk(1, 1, 0, 0, 0, 0));
        repeat (3) begin
            @(posedge pix_clk);
            #1 check("rst_hold_en", got_a(), mk(0, 0, 0, 0, 0, 0));
        end
        #1 en_a = 1'b0;
        @(posedge pix_clk);
        #2 rstn_a = 1'b1;
        repeat (2) @(posedge pix_clk);
        #2 en_a = 1'b1;
        @(posedge pix_clk);
        done_a = 0;

        for (int i = 0; i < NV; i++) begin
            at_a(vecs[i].t);
            check($sformatf("vec%0d_t%0d", i, vecs[i].t), got_a(),
                  mk(vecs[i].vs, vecs[i].hs, vecs[i].de, vecs[i].x, vecs[i].y, vecs[i].fs));
        end

        at_a(43660);
        check("act_x500", got_a(), mk(0, 0, 1, 500, 1, 0));
        #2 rstn_a = 1'b0;
        #1 check("async_rst_mid", got_a(), mk(0, 0, 0, 0, 0, 0));
        repeat (3) begin
            @(posedge pix_clk);
            #1 check("async_rst_hold", got_a(), mk(0, 0, 0, 0, 0, 0));
        end
        #1 en_a = 1'b0;
        @(posedge pix_clk);
        #2 rstn_a = 1'b1;
        repeat (6) begin
            @(posedge pix_clk);
            #1 check("no_glitch", got_a(), mk(0, 0, 0, 0, 0, 0));
        end

        #1 rstn_b = 1'b1;
        repeat (2) @(posedge pix_clk);
        #2 en_b = 1'b1;
        @(posedge pix_clk);
        done_b = 0;
        at_b(0);
        check("b_first_fs", got_b(), mk(0, 0, 0, 0, 0, 1));
        at_b(127);
        check("b_last_pix", got_b(), mk(1, 1, 0, 0, 0, 0));
        at_b(128);
        check("b_wrap_fs", got_b(), mk(0, 0, 0, 0, 0, 1));
        at_b(326);
        #1 en_b = 1'b0;
        @(posedge pix_clk);
        #1 check("en_fall_last", got_b(), mk(1, 1, 1, 2, 1, 0));
        @(posedge pix_clk);
        #1 check("en_fall_idle", got_b(), mk(1, 1, 0, 0, 0, 0));
        #1 en_b = 1'b1;
        @(posedge pix_clk);
        #1 check("en_rise_samp", got_b(), mk(1, 1, 0, 0, 0, 0));
        @(posedge pix_clk);
        #1 check("en_rise_fs", got_b(), mk(0, 0, 0, 0, 0, 1));
        done_b = 1;
        at_b(53);
        check("restart_y0", got_b(), mk(1, 1, 1, 0, 0, 0));
        at_b(69);
        check("restart_y1", got_b(), mk(1, 1, 1, 0, 1, 0));
        at_b(128);
        check("restart_wrap", got_b(), mk(0, 0, 0, 0, 0, 1));
        at_b(129);
        check("restart_h1", got_b(), mk(0, 0, 0, 0, 0, 0));

        repeat (4) @(posedge pix_clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
